// File: rtl/multi_channel_oversample_filter.sv
// N-channel time-multiplexed oversample averager: per-channel IDLE/DELAY/SAMPLE state,
// accumulator and config. Define OSF_ROUND_EN for round-half-up with saturation.
module multi_channel_oversample_filter #(
    parameter int N_CHAN    = 8,
    parameter int W_CHAN    = 3,
    parameter int W_DATA    = 18,
    parameter int W_EP      = 16,
    parameter int W_OSM     = 4,
    parameter int OSM_INIT  = 0,
    parameter int CDLY_INIT = 0
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic signed [W_DATA-1:0] data_in,
    input  logic [W_CHAN-1:0]        chan_in,
    input  logic                     data_valid_in,
    input  logic [N_CHAN-1:0]        activate_in,
    input  logic [W_CHAN-1:0]        cfg_chan_in,
    input  logic [W_OSM-1:0]         osm_in,
    input  logic [W_EP-1:0]          cycle_delay_in,
    input  logic                     update_en_in,
    input  logic                     update_in,
    output logic signed [W_DATA-1:0] data_out,
    output logic [W_CHAN-1:0]        chan_out,
    output logic                     data_valid_out
);

    localparam int MAX_OS = (1 << W_OSM) - 1;
    localparam int ACC_W  = W_DATA + MAX_OS;
    localparam int W_CNT  = (W_EP > MAX_OS + 1) ? W_EP : MAX_OS + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        SAMPLE = 2'd2
    } chan_state_e;

    // Per-channel context; ctx_q[c].state is the observable FSM state of channel c.
    typedef struct packed {
        chan_state_e       state;
        logic [ACC_W-1:0]  sum;
        logic [W_CNT-1:0]  cnt;
    } chan_ctx_t;

    chan_ctx_t        ctx_q  [N_CHAN];
    chan_ctx_t        ctx_d  [N_CHAN];
    logic [W_OSM-1:0] osm_q  [N_CHAN];
    logic [W_OSM-1:0] osm_d  [N_CHAN];
    logic [W_EP-1:0]  cdly_q [N_CHAN];
    logic [W_EP-1:0]  cdly_d [N_CHAN];

    logic [N_CHAN-1:0] data_hit;
    logic [N_CHAN-1:0] cfg_hit;
    logic [N_CHAN-1:0] take;
    logic [N_CHAN-1:0] full;
    logic [ACC_W-1:0]  acc_nxt [N_CHAN];
    logic [W_CNT-1:0]  cnt_nxt [N_CHAN];
    logic [ACC_W-1:0]  data_sx;

    logic              done_v;
    logic [W_CHAN-1:0] done_chan;
    logic [ACC_W-1:0]  done_acc;
    logic [W_OSM-1:0]  done_osm;
    logic signed [W_DATA-1:0] avg;

    logic signed [W_DATA-1:0] data_out_q, data_out_d;
    logic [W_CHAN-1:0]        chan_out_q, chan_out_d;
    logic                     data_valid_q, data_valid_d;

    assign data_sx = {{MAX_OS{data_in[W_DATA-1]}}, data_in};

    // Channel tags >= N_CHAN match no index, so such words and writes fall through.
    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            data_hit[c] = data_valid_in && (chan_in == W_CHAN'(c));
            cfg_hit[c]  = update_in && update_en_in && (cfg_chan_in == W_CHAN'(c));
            take[c]     = (ctx_q[c].state == SAMPLE) ||
                          ((ctx_q[c].state == DELAY) && (ctx_q[c].cnt >= W_CNT'(cdly_q[c])));
            acc_nxt[c]  = ((ctx_q[c].state == SAMPLE) ? ctx_q[c].sum : '0) + data_sx;
            cnt_nxt[c]  = ((ctx_q[c].state == SAMPLE) ? ctx_q[c].cnt : '0) + W_CNT'(1);
            full[c]     = (cnt_nxt[c] == (W_CNT'(1) << osm_q[c]));
        end
    end

    always_comb begin
        done_v    = 1'b0;
        done_chan = '0;
        done_acc  = '0;
        done_osm  = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            ctx_d[c]  = ctx_q[c];
            osm_d[c]  = osm_q[c];
            cdly_d[c] = cdly_q[c];
            if (cfg_hit[c]) begin
                osm_d[c]       = osm_in;
                cdly_d[c]      = cycle_delay_in;
                ctx_d[c].state = activate_in[c] ? SAMPLE : IDLE;
                ctx_d[c].sum   = '0;
                ctx_d[c].cnt   = '0;
            end else if (!activate_in[c]) begin
                ctx_d[c].state = IDLE;
                ctx_d[c].sum   = '0;
                ctx_d[c].cnt   = '0;
            end else if (ctx_q[c].state == IDLE) begin
                ctx_d[c].state = SAMPLE;
            end else if (data_hit[c]) begin
                if (!take[c]) begin
                    ctx_d[c].cnt = ctx_q[c].cnt + W_CNT'(1);
                end else if (full[c]) begin
                    ctx_d[c].state = DELAY;
                    ctx_d[c].sum   = '0;
                    ctx_d[c].cnt   = '0;
                    done_v         = 1'b1;
                    done_chan      = W_CHAN'(c);
                    done_acc       = acc_nxt[c];
                    done_osm       = osm_q[c];
                end else begin
                    ctx_d[c].state = SAMPLE;
                    ctx_d[c].sum   = acc_nxt[c];
                    ctx_d[c].cnt   = cnt_nxt[c];
                end
            end
        end
    end

`ifdef OSF_ROUND_EN
    logic [ACC_W:0] rnd_bias;
    logic [ACC_W:0] rnd_sum;
    logic [ACC_W:0] rnd_shr;

    always_comb begin
        rnd_bias = '0;
        if (done_osm != '0) begin
            rnd_bias = (ACC_W+1)'(1) << (done_osm - W_OSM'(1));
        end
        rnd_sum = {done_acc[ACC_W-1], done_acc} + rnd_bias;
        rnd_shr = $signed(rnd_sum) >>> done_osm;
        if (rnd_shr[ACC_W:W_DATA-1] == {(ACC_W-W_DATA+2){rnd_shr[ACC_W]}}) begin
            avg = rnd_shr[W_DATA-1:0];
        end else begin
            avg = {rnd_shr[ACC_W], {(W_DATA-1){~rnd_shr[ACC_W]}}};
        end
    end
`else
    assign avg = W_DATA'($signed(done_acc) >>> done_osm);
`endif

    // Output is valid-only (no ready): data_valid_out pulses one cycle per completed
    // average and data_out/chan_out hold their last value otherwise.
    always_comb begin
        data_valid_d = done_v;
        chan_out_d   = done_v ? done_chan : chan_out_q;
        data_out_d   = done_v ? avg : data_out_q;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int c = 0; c < N_CHAN; c++) begin
                ctx_q[c]  <= '{state: IDLE, sum: '0, cnt: '0};
                osm_q[c]  <= W_OSM'(OSM_INIT);
                cdly_q[c] <= W_EP'(CDLY_INIT);
            end
            data_out_q   <= '0;
            chan_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                ctx_q[c]  <= ctx_d[c];
                osm_q[c]  <= osm_d[c];
                cdly_q[c] <= cdly_d[c];
            end
            data_out_q   <= data_out_d;
            chan_out_q   <= chan_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign chan_out       = chan_out_q;
    assign data_valid_out = data_valid_q;

endmodule

// File: tb/tb_multi_channel_oversample_filter.sv
// Bench for multi_channel_oversample_filter: vector table plus hand sequences, with an
// expected-output queue checked on every data_valid_out pulse (value, channel, cycle).
module tb_multi_channel_oversample_filter;

    localparam int N_CHAN = 8;
    localparam int W_CHAN = 3;
    localparam int W_DATA = 18;
    localparam int W_EP   = 16;
    localparam int W_OSM  = 4;
    localparam int EXP_W  = 32 + W_CHAN + W_DATA;
`ifdef OSF_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                     clk_in = 1'b0;
    logic                     reset_n_in = 1'b1;
    logic signed [W_DATA-1:0] data_in = '0;
    logic [W_CHAN-1:0]        chan_in = '0;
    logic                     data_valid_in = 1'b0;
    logic [N_CHAN-1:0]        activate_in = '0;
    logic [W_CHAN-1:0]        cfg_chan_in = '0;
    logic [W_OSM-1:0]         osm_in = '0;
    logic [W_EP-1:0]          cycle_delay_in = '0;
    logic                     update_en_in = 1'b0;
    logic                     update_in = 1'b0;
    logic signed [W_DATA-1:0] data_out;
    logic [W_CHAN-1:0]        chan_out;
    logic                     data_valid_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_rec;

    typedef struct {
        int ch;
        int data;
        bit exp_v;
        int exp_d;
    } vec_t;
    vec_t vecs[19];

    multi_channel_oversample_filter #(
        .N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_DATA(W_DATA), .W_EP(W_EP),
        .W_OSM(W_OSM), .OSM_INIT(0), .CDLY_INIT(0)
    ) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .data_in(data_in), .chan_in(chan_in),
        .data_valid_in(data_valid_in), .activate_in(activate_in), .cfg_chan_in(cfg_chan_in),
        .osm_in(osm_in), .cycle_delay_in(cycle_delay_in), .update_en_in(update_en_in),
        .update_in(update_in), .data_out(data_out), .chan_out(chan_out),
        .data_valid_out(data_valid_out)
    );

    // Clock and reset-independent cycle counter
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the head of the expected queue
    always @(negedge clk_in) begin
        if (reset_n_in && data_valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: chan %0d data %0d, expected no output",
                         chan_out, data_out);
            end else begin
                mon_rec = exp_q.pop_front();
                check("out_data", int'(data_out), int'($signed(mon_rec[W_DATA-1:0])));
                check("out_chan", int'(chan_out), int'(mon_rec[W_CHAN+W_DATA-1:W_DATA]));
                check("out_cycle", cyc, int'(mon_rec[EXP_W-1:W_CHAN+W_DATA]));
            end
        end
    end

    // Driver tasks: entered and left #1 after a rising edge
    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_word(input int ch, input int d, input bit exp_v, input int exp_d);
        chan_in       = W_CHAN'(ch);
        data_in       = W_DATA'(d);
        data_valid_in = 1'b1;
        if (exp_v) exp_q.push_back({32'(cyc + 1), W_CHAN'(ch), W_DATA'(exp_d)});
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int osm, input int cdly, input bit en);
        cfg_chan_in    = W_CHAN'(ch);
        osm_in         = W_OSM'(osm);
        cycle_delay_in = W_EP'(cdly);
        update_en_in   = en;
        update_in      = 1'b1;
        @(posedge clk_in);
        #1;
        update_in      = 1'b0;
        update_en_in   = 1'b0;
    endtask

    task automatic cfg_and_word(input int cch, input int osm, input int ch, input int d);
        cfg_chan_in    = W_CHAN'(cch);
        osm_in         = W_OSM'(osm);
        cycle_delay_in = '0;
        update_en_in   = 1'b1;
        update_in      = 1'b1;
        chan_in        = W_CHAN'(ch);
        data_in        = W_DATA'(d);
        data_valid_in  = 1'b1;
        @(posedge clk_in);
        #1;
        update_in      = 1'b0;
        update_en_in   = 1'b0;
        data_valid_in  = 1'b0;
    endtask

    task automatic expect_drained(input string name);
        idle_cycles(3);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{0, 10, 1'b0, 0};
        vecs[1]  = '{0, 11, 1'b0, 0};
        vecs[2]  = '{0, 12, 1'b0, 0};
        vecs[3]  = '{0, 13, 1'b1, RND ? 12 : 11};
        vecs[4]  = '{3, 8, 1'b0, 0};
        vecs[5]  = '{1, -4, 1'b0, 0};
        vecs[6]  = '{3, 8, 1'b0, 0};
        vecs[7]  = '{1, -5, 1'b1, RND ? -4 : -5};
        vecs[8]  = '{3, 8, 1'b0, 0};
        vecs[9]  = '{3, 9, 1'b1, 8};
        vecs[10] = '{6, 500, 1'b0, 0};
        vecs[11] = '{7, -131072, 1'b1, -131072};
        vecs[12] = '{7, 131071, 1'b1, 131071};
        vecs[13] = '{0, 20, 1'b0, 0};
        vecs[14] = '{0, 21, 1'b0, 0};
        vecs[15] = '{0, 22, 1'b0, 0};
        vecs[16] = '{0, 23, 1'b1, RND ? 22 : 21};
        vecs[17] = '{1, -1, 1'b0, 0};
        vecs[18] = '{1, -2, 1'b1, RND ? -1 : -2};

        // Reset state
        #1 reset_n_in = 1'b0;
        #2;
        check("reset_data_out", int'(data_out), 0);
        check("reset_chan_out", int'(chan_out), 0);
        check("reset_valid", int'(data_valid_out), 0);
        idle_cycles(2);
        reset_n_in = 1'b1;
        idle_cycles(1);

        // Table: averaging, interleave, inactive channel, osm=0 extremes
        activate_in = 8'b1000_1011;
        idle_cycles(1);
        write_cfg(0, 2, 0, 1'b1);
        write_cfg(1, 1, 0, 1'b1);
        write_cfg(3, 2, 0, 1'b1);
        write_cfg(7, 0, 0, 1'b1);
        for (int i = 0; i < 19; i++) begin
            send_word(vecs[i].ch, vecs[i].data, vecs[i].exp_v, vecs[i].exp_d);
        end
        expect_drained("table_drained");

        // Settle delay: only words 1 and 5 pass
        write_cfg(0, 0, 3, 1'b1);
        for (int v = 1; v <= 8; v++) send_word(0, v, (v == 1) || (v == 5), v);
        expect_drained("delay_drained");

        // Write without update_en_in is ignored: ch7 stays pass-through
        write_cfg(7, 3, 0, 1'b0);
        send_word(7, 5, 1'b1, 5);
        expect_drained("update_en_drained");

        // Config and data on the same cycle for the same channel
        activate_in[4] = 1'b1;
        idle_cycles(1);
        write_cfg(4, 2, 0, 1'b1);
        send_word(4, 1, 1'b0, 0);
        send_word(4, 2, 1'b0, 0);
        cfg_and_word(4, 1, 4, 100);
        send_word(4, 6, 1'b0, 0);
        send_word(4, 8, 1'b1, 7);
        expect_drained("collision_drained");

        // Deactivate on the final word; re-activation samples without delay
        activate_in[5] = 1'b1;
        idle_cycles(1);
        write_cfg(5, 1, 2, 1'b1);
        send_word(5, 10, 1'b0, 0);
        activate_in[5] = 1'b0;
        send_word(5, 12, 1'b0, 0);
        send_word(7, 33, 1'b1, 33);
        activate_in[5] = 1'b1;
        idle_cycles(1);
        send_word(5, 2, 1'b0, 0);
        send_word(5, 4, 1'b1, 3);
        expect_drained("deactivate_drained");

        // Reset mid-accumulation
        activate_in[2] = 1'b1;
        idle_cycles(1);
        write_cfg(2, 3, 0, 1'b1);
        for (int v = 1; v <= 5; v++) send_word(2, v, 1'b0, 0);
        reset_n_in = 1'b0;
        #1;
        check("midreset_data_out", int'(data_out), 0);
        check("midreset_chan_out", int'(chan_out), 0);
        check("midreset_valid", int'(data_valid_out), 0);
        idle_cycles(2);
        reset_n_in = 1'b1;
        idle_cycles(1);
        write_cfg(2, 3, 0, 1'b1);
        for (int v = 1; v <= 8; v++) send_word(2, v, v == 8, RND ? 5 : 4);
        expect_drained("postreset_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
